pool_mem_handoff_1: RTL and testbench
=====================================

// Module: pool_mem_handoff_1
// PURPOSE
//  Port-ownership arbiter between layer 1 pool stage (producer, writes pool_memo_1) and layer 2 input stage (consumer, reads it).
//  Grants the pool-memory A/B control ports to one side at a time, gates producer enable, issues consumer start, tracks frames.
//  Drives the *_use_out address/rden/wren ports of layer_1; pool data path stays direct, only controls are arbitrated.
// PARAMETERS
//  POOL_ADDR_WIDTH  10  pool-memory address width (both ports)
//  RD_LATENCY       2   pool-memory read latency in cycles, rden to q (>=1)
//  FRAME_CNT_WIDTH  8   width of completed-frame counter
// PORTS
//  clock         in   1    single clock, all state on rising edge
//  reset         in   1    synchronous, active-high
//  enable        in   1    level; allows new frames to start
//  prod_addr_a   in   POOL_ADDR_WIDTH  producer port-A address (layer_1 address_a_t_out)
//  prod_addr_b   in   POOL_ADDR_WIDTH  producer port-B address
//  prod_rden_a/b in   1    producer read enables (read-modify for max-pool)
//  prod_wren_a/b in   1    producer write enables
//  prod_done     in   1    pulse: producer finished frame (pool_done)
//  cons_addr_a/b in   POOL_ADDR_WIDTH  consumer read addresses
//  cons_rden_a/b in   1    consumer read enables
//  cons_done     in   1    pulse: consumer finished reading frame
//  mem_addr_a/b  out  POOL_ADDR_WIDTH  to address_*_t_use_out
//  mem_rden_a/b  out  1    to rden_*_use_out
//  mem_wren_a/b  out  1    to wren_*_use_out
//  prod_enable   out  1    producer may run (layer_1 enable)
//  cons_start    out  1    one-cycle pulse: frame ready for consumer
//  q_valid_a/b   out  1    consumer read data valid on q_*_all_out
//  frame_count   out  FRAME_CNT_WIDTH  frames fully drained
//  err           out  1    sticky protocol-violation flag
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; q_valid pipes flushed. Reset mid-frame aborts; no partial-frame recovery.
//  FSM: IDLE -> FILL when enable=1.
//    FILL : owner=producer, prod_enable=1. prod_done=1 -> READY; prod_enable low from next cycle.
//    READY: cons_start=1 for exactly this one cycle, -> DRAIN unconditionally.
//    DRAIN: owner=consumer. cons_done=1 -> frame_count+1 (wraps 2^W-1 -> 0); enable=1 -> FILL, else -> IDLE.
//  Port mux registered: mem_* at cycle t+1 = owner inputs at t; producer rden allowed only in FILL.
//  No owner (IDLE/READY): mem_addr_*=0, mem_rden_*=0, mem_wren_*=0.
//  Consumer never writes: mem_wren_* = 0 in DRAIN regardless of inputs.
//  q_valid_x asserts exactly RD_LATENCY cycles after mem_rden_x, in DRAIN-sourced reads only (shift register).
//    In-flight valids complete after leaving DRAIN.
//  Violations set err (sticky until reset), offending request suppressed, FSM unaffected:
//    prod_wren_*/prod_rden_* outside FILL; cons_rden_* outside DRAIN; prod_done outside FILL; cons_done outside DRAIN.
//  prod_done and cons_done same cycle: only the one legal for current state acts; other flags err.
//  enable low mid-FILL/DRAIN: frame completes; only the DRAIN->FILL decision samples enable.
// TESTING
//  Reset, enable=1: FILL next cycle, prod_enable=1; all mem_* 0 during reset cycle.
//  FILL: prod_addr_a=0x05, prod_wren_a=1 at t -> mem_addr_a=0x05, mem_wren_a=1 at t+1.
//  prod_done pulse -> READY, cons_start high one cycle, DRAIN next; prod_enable 0.
//  DRAIN: cons_rden_b=1, cons_addr_b=0x3FF at t -> mem_rden_b=1 at t+1, q_valid_b=1 at t+3 (RD_LATENCY=2).
//  cons_done with enable=1 -> frame_count 0->1, back to FILL; repeat 256 frames -> frame_count wraps to 0.
//  prod_wren_a=1 during DRAIN -> mem_wren_a stays 0, err=1 held until reset; state sequence unchanged.

Source files
------------

// File: rtl/pool_mem_handoff_1_if.sv
// Control-port bundle between the pool-memory ownership arbiter and its environment.
// The master side drives producer/consumer requests; the slave side is the arbiter itself.
interface pool_mem_handoff_1_if #(
    parameter int POOL_ADDR_WIDTH = 10,
    parameter int FRAME_CNT_WIDTH = 8
);
    logic                       enable;
    logic [POOL_ADDR_WIDTH-1:0] prod_addr_a;
    logic [POOL_ADDR_WIDTH-1:0] prod_addr_b;
    logic                       prod_rden_a;
    logic                       prod_rden_b;
    logic                       prod_wren_a;
    logic                       prod_wren_b;
    logic                       prod_done;
    logic [POOL_ADDR_WIDTH-1:0] cons_addr_a;
    logic [POOL_ADDR_WIDTH-1:0] cons_addr_b;
    logic                       cons_rden_a;
    logic                       cons_rden_b;
    logic                       cons_done;
    logic [POOL_ADDR_WIDTH-1:0] mem_addr_a;
    logic [POOL_ADDR_WIDTH-1:0] mem_addr_b;
    logic                       mem_rden_a;
    logic                       mem_rden_b;
    logic                       mem_wren_a;
    logic                       mem_wren_b;
    logic                       prod_enable;
    logic                       cons_start;
    logic                       q_valid_a;
    logic                       q_valid_b;
    logic [FRAME_CNT_WIDTH-1:0] frame_count;
    logic                       err;

    modport master (
        output enable, prod_addr_a, prod_addr_b, prod_rden_a, prod_rden_b,
               prod_wren_a, prod_wren_b, prod_done,
               cons_addr_a, cons_addr_b, cons_rden_a, cons_rden_b, cons_done,
        input  mem_addr_a, mem_addr_b, mem_rden_a, mem_rden_b, mem_wren_a, mem_wren_b,
               prod_enable, cons_start, q_valid_a, q_valid_b, frame_count, err
    );

    modport slave (
        input  enable, prod_addr_a, prod_addr_b, prod_rden_a, prod_rden_b,
               prod_wren_a, prod_wren_b, prod_done,
               cons_addr_a, cons_addr_b, cons_rden_a, cons_rden_b, cons_done,
        output mem_addr_a, mem_addr_b, mem_rden_a, mem_rden_b, mem_wren_a, mem_wren_b,
               prod_enable, cons_start, q_valid_a, q_valid_b, frame_count, err
    );
endinterface

// File: rtl/pool_mem_handoff_1.sv
// Hands the pool-memory A/B control ports between the layer-1 pool producer and the
// layer-2 input consumer, one frame at a time, with registered port mux and read-valid tracking.
module pool_mem_handoff_1 #(
    parameter int POOL_ADDR_WIDTH = 10,
    parameter int RD_LATENCY      = 2,
    parameter int FRAME_CNT_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    pool_mem_handoff_1_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, READY, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [POOL_ADDR_WIDTH-1:0] mem_addr_a_q, mem_addr_b_q;
    logic                       mem_rden_a_q, mem_rden_b_q;
    logic                       mem_wren_a_q, mem_wren_b_q;
    logic                       cons_src_q;
    logic                       prod_enable_q, cons_start_q;
    logic [FRAME_CNT_WIDTH-1:0] frame_count_q;
    logic                       err_q;
    logic                       viol;
    logic [RD_LATENCY-1:0]      vpipe_a_q, vpipe_b_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable) state_d = FILL;
            FILL:    if (bus.prod_done) state_d = READY;
            READY:   state_d = DRAIN;
            DRAIN:   if (bus.cons_done) state_d = bus.enable ? FILL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Any request arriving while its side does not own the ports is an error; the mux drops it.
    always_comb begin
        viol = 1'b0;
        if (state_q != FILL && (bus.prod_wren_a || bus.prod_wren_b || bus.prod_rden_a ||
                                bus.prod_rden_b || bus.prod_done))
            viol = 1'b1;
        if (state_q != DRAIN && (bus.cons_rden_a || bus.cons_rden_b || bus.cons_done))
            viol = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_addr_a_q  <= '0;
            mem_addr_b_q  <= '0;
            mem_rden_a_q  <= 1'b0;
            mem_rden_b_q  <= 1'b0;
            mem_wren_a_q  <= 1'b0;
            mem_wren_b_q  <= 1'b0;
            cons_src_q    <= 1'b0;
            prod_enable_q <= 1'b0;
            cons_start_q  <= 1'b0;
            frame_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            prod_enable_q <= (state_d == FILL);
            cons_start_q  <= (state_d == READY);
            err_q         <= err_q | viol;
            cons_src_q    <= (state_q == DRAIN);
            if (state_q == DRAIN && bus.cons_done)
                frame_count_q <= frame_count_q + FRAME_CNT_WIDTH'(1);
            case (state_q)
                FILL: begin
                    mem_addr_a_q <= bus.prod_addr_a;
                    mem_addr_b_q <= bus.prod_addr_b;
                    mem_rden_a_q <= bus.prod_rden_a;
                    mem_rden_b_q <= bus.prod_rden_b;
                    mem_wren_a_q <= bus.prod_wren_a;
                    mem_wren_b_q <= bus.prod_wren_b;
                end
                DRAIN: begin
                    mem_addr_a_q <= bus.cons_addr_a;
                    mem_addr_b_q <= bus.cons_addr_b;
                    mem_rden_a_q <= bus.cons_rden_a;
                    mem_rden_b_q <= bus.cons_rden_b;
                    mem_wren_a_q <= 1'b0;
                    mem_wren_b_q <= 1'b0;
                end
                default: begin
                    mem_addr_a_q <= '0;
                    mem_addr_b_q <= '0;
                    mem_rden_a_q <= 1'b0;
                    mem_rden_b_q <= 1'b0;
                    mem_wren_a_q <= 1'b0;
                    mem_wren_b_q <= 1'b0;
                end
            endcase
        end
    end

    // Valid pipes start from the issued read, so only consumer reads ever produce q_valid.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_vpipe
            always_ff @(posedge clock) begin
                if (reset) begin
                    vpipe_a_q[gi] <= 1'b0;
                    vpipe_b_q[gi] <= 1'b0;
                end else if (gi == 0) begin
                    vpipe_a_q[gi] <= mem_rden_a_q & cons_src_q;
                    vpipe_b_q[gi] <= mem_rden_b_q & cons_src_q;
                end else begin
                    vpipe_a_q[gi] <= vpipe_a_q[(gi == 0) ? 0 : gi-1];
                    vpipe_b_q[gi] <= vpipe_b_q[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign bus.mem_addr_a  = mem_addr_a_q;
    assign bus.mem_addr_b  = mem_addr_b_q;
    assign bus.mem_rden_a  = mem_rden_a_q;
    assign bus.mem_rden_b  = mem_rden_b_q;
    assign bus.mem_wren_a  = mem_wren_a_q;
    assign bus.mem_wren_b  = mem_wren_b_q;
    assign bus.prod_enable = prod_enable_q;
    assign bus.cons_start  = cons_start_q;
    assign bus.q_valid_a   = vpipe_a_q[RD_LATENCY-1];
    assign bus.q_valid_b   = vpipe_b_q[RD_LATENCY-1];
    assign bus.frame_count = frame_count_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_pool_mem_handoff_1.sv
// Directed bench for the pool-memory handoff arbiter: ownership sequence, port mux,
// read-valid latency, protocol errors and frame-counter wrap.
module tb_pool_mem_handoff_1;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    pool_mem_handoff_1_if #(.POOL_ADDR_WIDTH(10), .FRAME_CNT_WIDTH(8)) bus ();

    pool_mem_handoff_1 #(
        .POOL_ADDR_WIDTH(10),
        .RD_LATENCY     (2),
        .FRAME_CNT_WIDTH(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_reqs();
        bus.prod_addr_a = '0;
        bus.prod_addr_b = '0;
        bus.prod_rden_a = 1'b0;
        bus.prod_rden_b = 1'b0;
        bus.prod_wren_a = 1'b0;
        bus.prod_wren_b = 1'b0;
        bus.prod_done   = 1'b0;
        bus.cons_addr_a = '0;
        bus.cons_addr_b = '0;
        bus.cons_rden_a = 1'b0;
        bus.cons_rden_b = 1'b0;
        bus.cons_done   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_reqs();
        bus.enable = 1'b1;
        reset      = 1'b1;
        // Requests during reset must not leak to the memory ports.
        bus.prod_addr_a = 10'h155;
        bus.prod_wren_a = 1'b1;
        tick();
        tick();
        check("rst_mem_addr_a", 32'(bus.mem_addr_a), 32'h0);
        check("rst_mem_wren_a", 32'(bus.mem_wren_a), 32'h0);
        check("rst_prod_enable", 32'(bus.prod_enable), 32'h0);
        check("rst_frame_count", 32'(bus.frame_count), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        clear_reqs();
        reset = 1'b0;

        tick();
        check("fill_prod_enable", 32'(bus.prod_enable), 32'h1);
        check("fill_cons_start", 32'(bus.cons_start), 32'h0);

        bus.prod_addr_a = 10'h005;
        bus.prod_wren_a = 1'b1;
        bus.prod_addr_b = 10'h012;
        bus.prod_rden_b = 1'b1;
        tick();
        check("fill_mem_addr_a", 32'(bus.mem_addr_a), 32'h005);
        check("fill_mem_wren_a", 32'(bus.mem_wren_a), 32'h1);
        check("fill_mem_addr_b", 32'(bus.mem_addr_b), 32'h012);
        check("fill_mem_rden_b", 32'(bus.mem_rden_b), 32'h1);
        clear_reqs();
        tick();
        check("fill_mem_wren_a_off", 32'(bus.mem_wren_a), 32'h0);
        check("fill_prod_read_no_qvalid", 32'(bus.q_valid_b), 32'h0);
        tick();
        check("fill_prod_read_no_qvalid2", 32'(bus.q_valid_b), 32'h0);

        bus.prod_done = 1'b1;
        tick();
        clear_reqs();
        check("ready_cons_start", 32'(bus.cons_start), 32'h1);
        check("ready_prod_enable", 32'(bus.prod_enable), 32'h0);
        tick();
        check("drain_cons_start_low", 32'(bus.cons_start), 32'h0);
        check("drain_prod_enable", 32'(bus.prod_enable), 32'h0);
        check("drain_mem_addr_a_idle", 32'(bus.mem_addr_a), 32'h0);

        bus.cons_rden_b = 1'b1;
        bus.cons_addr_b = 10'h3FF;
        tick();
        clear_reqs();
        check("drain_mem_rden_b", 32'(bus.mem_rden_b), 32'h1);
        check("drain_mem_addr_b", 32'(bus.mem_addr_b), 32'h3FF);
        check("drain_qv_b_t1", 32'(bus.q_valid_b), 32'h0);
        tick();
        check("drain_qv_b_t2", 32'(bus.q_valid_b), 32'h0);
        tick();
        check("drain_qv_b_t3", 32'(bus.q_valid_b), 32'h1);
        check("drain_qv_a_t3", 32'(bus.q_valid_a), 32'h0);
        tick();
        check("drain_qv_b_t4", 32'(bus.q_valid_b), 32'h0);

        bus.prod_wren_a = 1'b1;
        bus.prod_addr_a = 10'h0AA;
        tick();
        clear_reqs();
        check("viol_mem_wren_a", 32'(bus.mem_wren_a), 32'h0);
        check("viol_err", 32'(bus.err), 32'h1);
        check("viol_still_drain", 32'(bus.prod_enable), 32'h0);
        tick();
        check("viol_err_sticky", 32'(bus.err), 32'h1);

        bus.cons_done = 1'b1;
        tick();
        clear_reqs();
        check("frame1_count", 32'(bus.frame_count), 32'h1);
        check("frame1_back_to_fill", 32'(bus.prod_enable), 32'h1);

        for (int f = 1; f < 256; f++) begin
            bus.prod_done = 1'b1;
            tick();
            clear_reqs();
            tick();
            bus.cons_done = 1'b1;
            tick();
            clear_reqs();
        end
        check("wrap_frame_count", 32'(bus.frame_count), 32'h0);
        check("wrap_in_fill", 32'(bus.prod_enable), 32'h1);

        bus.enable    = 1'b0;
        bus.prod_done = 1'b1;
        tick();
        clear_reqs();
        check("noen_ready_cons_start", 32'(bus.cons_start), 32'h1);
        tick();
        bus.cons_done = 1'b1;
        tick();
        clear_reqs();
        check("noen_idle_prod_enable", 32'(bus.prod_enable), 32'h0);
        check("noen_frame_count", 32'(bus.frame_count), 32'h1);
        tick();
        check("noen_stays_idle", 32'(bus.prod_enable), 32'h0);
        check("err_held", 32'(bus.err), 32'h1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_err", 32'(bus.err), 32'h0);
        check("rst2_frame_count", 32'(bus.frame_count), 32'h0);

        bus.cons_done = 1'b1;
        tick();
        clear_reqs();
        check("idle_cons_done_err", 32'(bus.err), 32'h1);
        check("idle_cons_done_count", 32'(bus.frame_count), 32'h0);
        check("idle_no_fill", 32'(bus.prod_enable), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
